// File: rtl/buf_chain_delay_meter.sv
// Launch/capture controller for an external buffer-chain delay line.
// Toggles the chain input, synchronizes the chain output back into clk,
// and counts mismatch cycles until the launched edge returns. Repeats for
// a programmable number of trials with alternating edge polarity.
//
// Handshake: start is a level sampled only while IDLE; one accepted start
// produces exactly one done pulse, and busy covers the cycles in between.
module buf_chain_delay_meter #(
    parameter int CNT_W       = 16,
    parameter int TR_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TR_W-1:0]       trials,
    output logic                  launch,
    input  logic                  ret,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      last,
    output logic [CNT_W+TR_W-1:0] acc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A mismatch seen while the counter holds this value would push it to
    // the all-ones limit, so that cycle aborts instead of incrementing.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t                  state_q, state_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [TR_W-1:0]         idx_q, idx_n;
    logic [TR_W-1:0]         tgt_q, tgt_n;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    launch_n, timeout_n;
    logic [CNT_W-1:0]        last_n;
    logic [CNT_W+TR_W-1:0]   acc_n;
    logic                    busy_n, done_n;
    logic                    ret_s, mismatch;
    logic [TR_W-1:0]         idx_inc;

    assign ret_s    = sync_q[SYNC_STAGES-1];
    assign mismatch = (ret_s != launch);
    assign idx_inc  = idx_q + TR_W'(1);

    // Synchronizer for the asynchronous chain output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ret};
        end
    end

    // State and datapath registers; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
            launch  <= 1'b0;
            timeout <= 1'b0;
            last    <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            tgt_q   <= tgt_n;
            launch  <= launch_n;
            timeout <= timeout_n;
            last    <= last_n;
            acc     <= acc_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and datapath updates for the measurement sequence.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        tgt_n     = tgt_q;
        launch_n  = launch;
        timeout_n = timeout;
        last_n    = last;
        acc_n     = acc;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_n     = '0;
                    last_n    = '0;
                    timeout_n = 1'b0;
                    idx_n     = '0;
                    cnt_n     = '0;
                    tgt_n     = (trials == '0) ? TR_W'(1) : trials;
                    state_n   = S_ARM;
                end
            end
            S_ARM: begin
                // Chain must settle to the current launch level first.
                if (mismatch) begin
                    if (cnt_q == CNT_LAST) begin
                        timeout_n = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                launch_n = ~launch;
                state_n  = S_WAIT;
            end
            S_WAIT: begin
                if (mismatch) begin
                    if (cnt_q == CNT_LAST) begin
                        timeout_n = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end else begin
                    last_n  = cnt_q;
                    acc_n   = acc + (CNT_W+TR_W)'(cnt_q);
                    idx_n   = idx_inc;
                    cnt_n   = '0;
                    state_n = (idx_inc == tgt_q) ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n == S_ARM) || (state_n == S_LAUNCH) || (state_n == S_WAIT);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_buf_chain_delay_meter.sv
// Bench for buf_chain_delay_meter: one default instance and one with a
// 4-bit counter so timeouts are reachable. The chain is modelled as a
// shift register of launch, a stuck-high line, or a line that follows
// launch until it first goes high and then sticks.
module tb_buf_chain_delay_meter;

    localparam int SYNC  = 2;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [3:0] trials_in = 4'd0;
    logic       launch_a, launch_b, ret_a, ret_b;
    logic       busy_a, busy_b, done_a, done_b, timeout_a, timeout_b;
    logic [15:0] last_a;
    logic [3:0]  last_b;
    logic [19:0] acc_a;
    logic [7:0]  acc_b;

    logic [1:0] mode = 2'd0;   // 0 delay line, 1 stuck high, 2 follow then stick
    logic [2:0] dly  = 3'd0;
    logic [7:0] dl_a = '0, dl_b = '0;
    logic       stick_a = 1'b0, stick_b = 1'b0;

    logic        sel = 1'b0;
    logic        launch_m, busy_m, done_m, timeout_m;
    logic [15:0] last_m;
    logic [19:0] acc_m;

    int nvec = 0;
    int nerr = 0;
    int seen_last[$];
    logic done_after, busy_after;
    logic exp_launch_a = 1'b0, exp_launch_b = 1'b0;

    buf_chain_delay_meter u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .trials(trials_in),
        .launch(launch_a), .ret(ret_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .last(last_a), .acc(acc_a)
    );

    buf_chain_delay_meter #(.CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .trials(trials_in),
        .launch(launch_b), .ret(ret_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .last(last_b), .acc(acc_b)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_launch_a = 1'b0;
        exp_launch_b = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    // Chain models
    always @(posedge clk) begin
        dl_a <= {dl_a[6:0], launch_a};
        dl_b <= {dl_b[6:0], launch_b};
        if (mode != 2'd2) begin
            stick_a <= 1'b0;
            stick_b <= 1'b0;
        end else begin
            if (launch_a) stick_a <= 1'b1;
            if (launch_b) stick_b <= 1'b1;
        end
    end

    always_comb begin
        ret_a = launch_a;
        ret_b = launch_b;
        case (mode)
            2'd0: begin
                if (dly != 3'd0) begin
                    ret_a = dl_a[dly - 3'd1];
                    ret_b = dl_b[dly - 3'd1];
                end
            end
            2'd1: begin
                ret_a = 1'b1;
                ret_b = 1'b1;
            end
            default: begin
                ret_a = stick_a | launch_a;
                ret_b = stick_b | launch_b;
            end
        endcase
    end

    always_comb begin
        launch_m  = sel ? launch_b  : launch_a;
        busy_m    = sel ? busy_b    : busy_a;
        done_m    = sel ? done_b    : done_a;
        timeout_m = sel ? timeout_b : timeout_a;
        last_m    = sel ? {12'd0, last_b} : last_a;
        acc_m     = sel ? {12'd0, acc_b}  : acc_a;
    end

    // Driver: one measurement on the selected instance. n returns the edge
    // (counted from the accepting edge) at which done rose, -1 if never.
    task automatic set_start(input logic s, input logic v);
        if (s) start_b = v; else start_a = v;
    endtask

    task automatic run_meas(input logic s, input logic [3:0] t, input int glitch_at,
                            input logic start_at_done, output int n);
        logic [19:0] prev_acc;
        sel = s;
        trials_in = t;
        seen_last.delete();
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        prev_acc = acc_m;
        n = 0;
        while (n < LIMIT) begin
            set_start(s, (n == glitch_at));
            @(posedge clk);
            #1;
            n++;
            set_start(s, 1'b0);
            if (acc_m != prev_acc) begin
                seen_last.push_back(int'(last_m));
                prev_acc = acc_m;
            end
            if (done_m) break;
        end
        if (!done_m) n = -1;
        set_start(s, start_at_done);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        done_after = done_m;
        busy_after = busy_m;
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nvec++; if (launch_m !== 1'b0) begin nerr++; $display("FAIL reset_launch[%0d]: got %b exp 0", s, launch_m); end
            nvec++; if (busy_m !== 1'b0) begin nerr++; $display("FAIL reset_busy[%0d]: got %b exp 0", s, busy_m); end
            nvec++; if (done_m !== 1'b0) begin nerr++; $display("FAIL reset_done[%0d]: got %b exp 0", s, done_m); end
            nvec++; if (timeout_m !== 1'b0) begin nerr++; $display("FAIL reset_timeout[%0d]: got %b exp 0", s, timeout_m); end
            nvec++; if (last_m !== 16'd0) begin nerr++; $display("FAIL reset_last[%0d]: got %0d exp 0", s, last_m); end
            nvec++; if (acc_m !== 20'd0) begin nerr++; $display("FAIL reset_acc[%0d]: got %0d exp 0", s, acc_m); end
        end
    endtask

    // Random and directed delay runs share this reference: each trial counts
    // SYNC+d mismatch cycles, costs LAUNCH + (count+1) WAIT cycles, plus one ARM.
    task automatic test_delay(input string nm, input logic s, input logic [2:0] d, input logic [3:0] t);
        int n, teff, cnt, exp_n;
        logic exp_l;
        mode = 2'd0;
        dly = d;
        repeat (12) @(posedge clk);
        teff  = (t == 4'd0) ? 1 : int'(t);
        cnt   = SYNC + int'(d);
        exp_n = 1 + teff * (cnt + 2);
        exp_l = (s ? exp_launch_b : exp_launch_a) ^ teff[0];
        run_meas(s, t, -1, 1'b0, n);
        nvec++; if (n !== exp_n) begin nerr++; $display("FAIL %s cycles: got %0d exp %0d", nm, n, exp_n); end
        nvec++; if (last_m !== 16'(cnt)) begin nerr++; $display("FAIL %s last: got %0d exp %0d", nm, last_m, cnt); end
        nvec++; if (acc_m !== 20'(teff * cnt)) begin nerr++; $display("FAIL %s acc: got %0d exp %0d", nm, acc_m, teff * cnt); end
        nvec++; if (launch_m !== exp_l) begin nerr++; $display("FAIL %s launch: got %b exp %b", nm, launch_m, exp_l); end
        nvec++; if (timeout_m !== 1'b0) begin nerr++; $display("FAIL %s timeout: got %b exp 0", nm, timeout_m); end
        nvec++; if (seen_last.size() !== teff) begin nerr++; $display("FAIL %s trials_seen: got %0d exp %0d", nm, seen_last.size(), teff); end
        foreach (seen_last[i]) begin
            nvec++; if (seen_last[i] !== cnt) begin nerr++; $display("FAIL %s trial%0d_last: got %0d exp %0d", nm, i, seen_last[i], cnt); end
        end
        nvec++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin nerr++; $display("FAIL %s done_one_pulse: got done=%b busy=%b exp 0 0", nm, done_after, busy_after); end
        if (s) exp_launch_b = exp_l; else exp_launch_a = exp_l;
    endtask

    task automatic test_wait_timeout();
        int n;
        mode = 2'd2;
        repeat (4) @(posedge clk);
        run_meas(1'b1, 4'd3, -1, 1'b0, n);
        nvec++; if (n !== 21) begin nerr++; $display("FAIL wait_to cycles: got %0d exp 21", n); end
        nvec++; if (timeout_m !== 1'b1) begin nerr++; $display("FAIL wait_to timeout: got %b exp 1", timeout_m); end
        nvec++; if (last_m !== 16'd2) begin nerr++; $display("FAIL wait_to last: got %0d exp 2", last_m); end
        nvec++; if (acc_m !== 20'd2) begin nerr++; $display("FAIL wait_to acc: got %0d exp 2", acc_m); end
        nvec++; if (launch_m !== 1'b0) begin nerr++; $display("FAIL wait_to launch: got %b exp 0", launch_m); end
        nvec++; if (done_after !== 1'b0) begin nerr++; $display("FAIL wait_to done_one_pulse: got %b exp 0", done_after); end
        mode = 2'd0;
        dly = 3'd0;
    endtask

    task automatic test_arm_timeout();
        int n;
        mode = 2'd1;
        do_reset();
        run_meas(1'b1, 4'd2, -1, 1'b0, n);
        nvec++; if (n !== 15) begin nerr++; $display("FAIL arm_to cycles: got %0d exp 15", n); end
        nvec++; if (timeout_m !== 1'b1) begin nerr++; $display("FAIL arm_to timeout: got %b exp 1", timeout_m); end
        nvec++; if (launch_m !== 1'b0) begin nerr++; $display("FAIL arm_to launch: got %b exp 0", launch_m); end
        nvec++; if (acc_m !== 20'd0) begin nerr++; $display("FAIL arm_to acc: got %0d exp 0", acc_m); end
        nvec++; if (seen_last.size() !== 0) begin nerr++; $display("FAIL arm_to trials_seen: got %0d exp 0", seen_last.size()); end
        mode = 2'd0;
        dly = 3'd0;
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 2'd0;
        dly = 3'd3;
        repeat (12) @(posedge clk);
        // start re-asserted mid-measurement and again while done is high
        run_meas(1'b0, 4'd2, 4, 1'b1, n);
        nvec++; if (n !== 15) begin nerr++; $display("FAIL b2b cycles: got %0d exp 15", n); end
        nvec++; if (acc_m !== 20'd10) begin nerr++; $display("FAIL b2b acc: got %0d exp 10", acc_m); end
        nvec++; if (last_m !== 16'd5) begin nerr++; $display("FAIL b2b last: got %0d exp 5", last_m); end
        nvec++; if (busy_after !== 1'b0) begin nerr++; $display("FAIL b2b start_at_done busy: got %b exp 0", busy_after); end
        repeat (5) @(posedge clk);
        #1;
        nvec++; if (busy_m !== 1'b0 || acc_m !== 20'd10) begin nerr++; $display("FAIL b2b hold: got busy=%b acc=%0d exp 0 10", busy_m, acc_m); end
        nvec++; if (launch_m !== exp_launch_a) begin nerr++; $display("FAIL b2b launch: got %b exp %b", launch_m, exp_launch_a); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0;
        dly = 3'd5;
        sel = 1'b1;
        trials_in = 4'd4;
        repeat (12) @(posedge clk);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        nvec++; if (busy_m !== 1'b0 || done_m !== 1'b0 || timeout_m !== 1'b0) begin nerr++; $display("FAIL rst_mid flags: got busy=%b done=%b to=%b exp 0 0 0", busy_m, done_m, timeout_m); end
        nvec++; if (launch_m !== 1'b0) begin nerr++; $display("FAIL rst_mid launch: got %b exp 0", launch_m); end
        nvec++; if (last_m !== 16'd0 || acc_m !== 20'd0) begin nerr++; $display("FAIL rst_mid data: got last=%0d acc=%0d exp 0 0", last_m, acc_m); end
        @(negedge clk) rst_n = 1'b1;
        exp_launch_a = 1'b0;
        exp_launch_b = 1'b0;
        test_delay("after_rst", 1'b1, 3'd0, 4'd3);
    endtask

    initial begin
        test_reset();
        test_delay("zero_delay", 1'b0, 3'd0, 4'd4);
        test_delay("delay5", 1'b0, 3'd5, 4'd3);
        test_wait_timeout();
        test_arm_timeout();
        test_delay("trials0", 1'b0, 3'd0, 4'd0);
        nvec++; if (launch_a !== 1'b1) begin nerr++; $display("FAIL trials0 launch_end: got %b exp 1", launch_a); end
        test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            test_delay("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)));
        end
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/buf_chain_delay_meter.md
# buf_chain_delay_meter

Launch/capture controller that sits at both ends of an external chain of gf180mcu 9T buffer cells in OpenFASOC characterization and sensor macros. It toggles the chain input, synchronizes the chain output back into the clock domain, and counts clock cycles until the edge returns. The measurement repeats for a programmable number of trials, alternating rising and falling launches, and reports the last and accumulated counts.

## Interface
- CNT_W, 16, width of the per-trial cycle counter; a trial times out at 2^CNT_W-1 mismatch cycles.
- TR_W, 4, width of the trial-count input; accumulator width is CNT_W+TR_W.
- SYNC_STAGES, 2, flops in the `ret` synchronizer (≥2).

- clk  input  1  sampling clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a measurement; sampled only in IDLE.
- trials  input  TR_W  number of trials; 0 is treated as 1.
- launch  output  1  registered drive into the buffer chain input.
- ret  input  1  buffer chain output; asynchronous to clk.
- busy  output  1  high from the cycle after `start` is accepted until `done`.
- done  output  1  one-cycle pulse when the measurement ends (normal or timeout).
- timeout  output  1  set if the measurement aborted; cleared on the next accepted start.
- last  output  CNT_W  count of the most recent completed trial.
- acc  output  CNT_W+TR_W  sum of completed trial counts.

## Operation
- The synchronizer output is `ret_s`, the last of SYNC_STAGES flops clocked from `ret`. A cycle is a mismatch when `ret_s != launch`.
- States:
  - IDLE. On `start`, clear `acc`, `last`, `timeout`, the trial index and the counter, then go to ARM.
  - ARM. Wait for a match so the chain has settled. Each mismatch cycle increments the counter. When the counter reaches 2^CNT_W-1, abort. On a match, clear the counter and go to LAUNCH.
  - LAUNCH. Lasts one cycle: `launch` toggles, then go to WAIT.
  - WAIT. Each mismatch cycle increments the counter. On the first matching cycle:
    - `last` ← counter and `acc` ← `acc` + counter.
    - Increment the trial index and clear the counter.
    - If the index equals max(`trials`,1), go to DONE; otherwise go to LAUNCH.
    - If the counter reaches 2^CNT_W-1 while still mismatched, abort.
  - DONE. Lasts one cycle: `done`=1, then go to IDLE.
  - Abort. Set `timeout`=1 and go to DONE. `acc` and `last` keep the values from completed trials, and `launch` keeps its value.
- Count definition: the number of WAIT cycles with a mismatch. With zero chain delay the count is SYNC_STAGES. A chain delay of d whole cycles gives SYNC_STAGES+d.
- Trials alternate edge polarity because `launch` toggles every trial. `launch` is not restored at the end.
- Arithmetic: the counter saturates into timeout and never wraps. `acc` cannot overflow (at most (2^TR_W-1)·(2^CNT_W-2)). `trials` is sampled once, at start.
- `start` is ignored while busy. A `start` in the same cycle as `done` is ignored; it is accepted only in IDLE.
- Reset mid-operation returns to IDLE with every output at its reset value, and clears the synchronizer.

## Timing
- Reset values: `launch`=0, `busy`=0, `done`=0, `timeout`=0, `last`=0, `acc`=0, synchronizer all 0, state IDLE.
- `start` is accepted at edge E. `busy`=1 from E, and ARM occupies the cycle after E.
- When `ret_s` already matches at start, ARM is one cycle, LAUNCH one cycle, and `launch` toggles at the edge ending LAUNCH.
- Per trial: 1 LAUNCH cycle plus (count+1) WAIT cycles.
- `done` goes high in the cycle after the last WAIT cycle, and `busy` falls at the same edge. `last`, `acc` and `timeout` are valid when `done`=1 and hold until the next accepted start.
- All outputs are registered; there is no combinational path from `ret` or `start` to any output.

## Test plan
- `ret` tied to `launch`, `trials`=4, defaults → every trial gives `last`=2; `acc`=8; `launch` ends 0; `done` pulses once; `timeout`=0.
- `ret` is `launch` delayed 5 cycles through a bench shift register, `trials`=3 → `last`=7, `acc`=21; rising and falling launches give identical counts.
- CNT_W=4; `ret` follows `launch` for trial 1, then sticks at 1 with `trials`=3 → `last`=2, `acc`=2; after 15 mismatch cycles in trial 2, `timeout`=1 and `done` pulses.
- `ret` stuck at 1 from reset, `start` pulsed → ARM times out after 15 cycles (CNT_W=4); `launch` never toggles; `acc`=0; `timeout`=1.
- `trials`=0 with a zero-delay loop → exactly one trial; `acc`=2; `launch`=1 at `done`.
- `start` pulsed while busy → ignored and results unchanged. `rst_n` asserted mid-WAIT → all outputs 0 immediately. A later `start` runs a clean measurement with `acc`=2·`trials`.
